// File: rtl/segment_swap_ctl_pkg.sv
// segment_swap_ctl shared types: transition modes, controller states,
// and the infinite-repeat marker.
package segment_swap_ctl_pkg;

  typedef enum logic [7:0] {
    TRANSITION_MODE_SYNC_IDX = 8'h00,
    TRANSITION_MODE_SYS_TIME = 8'h01,
    TRANSITION_MODE_GPIO     = 8'h02,
    TRANSITION_MODE_EXT      = 8'hF0
  } transition_mode_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    HALT
  } swap_state_t;

  localparam logic [63:0] RepInfinite = '1;

endpackage

// File: rtl/segment_swap_ctl_if.sv
// Request, loop/timing inputs and status outputs of one
// segment_swap_ctl instance.
interface segment_swap_ctl_if #(
  parameter int SysTimeWidth = 56,
  parameter int RepWidth     = 16
);
  logic                    REQ_VALID;
  logic                    REQ_SEGMENT;
  logic [7:0]              REQ_MODE;
  logic [63:0]             REQ_VALUE;
  logic [RepWidth-1:0]     REP0;
  logic [RepWidth-1:0]     REP1;
  logic                    LOOP_END;
  logic [SysTimeWidth-1:0] SYS_TIME;
  logic [3:0]              GPIO_IN;
  logic                    SEGMENT;
  logic                    SWAP;
  logic                    BUSY;
  logic                    STOP;
  logic                    ERR;

  modport master (
    output REQ_VALID, REQ_SEGMENT, REQ_MODE, REQ_VALUE,
    output REP0, REP1, LOOP_END, SYS_TIME, GPIO_IN,
    input  SEGMENT, SWAP, BUSY, STOP, ERR
  );

  modport slave (
    input  REQ_VALID, REQ_SEGMENT, REQ_MODE, REQ_VALUE,
    input  REP0, REP1, LOOP_END, SYS_TIME, GPIO_IN,
    output SEGMENT, SWAP, BUSY, STOP, ERR
  );
endinterface

// File: rtl/segment_swap_ctl_trigger.sv
// segment_transition_trigger: mode decode and GPIO edge register.
// GPIO mode exists only with AUTD_TRANSITION_GPIO_EN defined.
module segment_transition_trigger
  import segment_swap_ctl_pkg::*;
#(
  parameter int SysTimeWidth = 56
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [7:0]              mode_i,
  input  logic [SysTimeWidth-1:0] tgt_i,
  input  logic [1:0]              idx_i,
  input  logic                    halted_i,
  input  logic                    loop_end_i,
  input  logic [SysTimeWidth-1:0] sys_time_i,
  input  logic [3:0]              gpio_i,
  input  logic [7:0]              req_mode_i,
  output logic                    trig_o,
  output logic                    mode_ok_o
);

  logic gpio_hit;
  logic gpio_en;

`ifdef AUTD_TRANSITION_GPIO_EN
  logic [3:0] gpio_q;
  logic [3:0] edge_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      gpio_q <= '0;
      edge_q <= '0;
    end else begin
      gpio_q <= gpio_i;
      edge_q <= gpio_i & ~gpio_q;
    end
  end

  assign gpio_hit = edge_q[idx_i];
  assign gpio_en  = 1'b1;
`else
  logic unused_gpio;
  assign unused_gpio = ^{gpio_i, idx_i};
  assign gpio_hit    = 1'b0;
  assign gpio_en     = 1'b0;
`endif

  assign mode_ok_o =
    (req_mode_i == TRANSITION_MODE_SYNC_IDX) |
    (req_mode_i == TRANSITION_MODE_SYS_TIME) |
    (req_mode_i == TRANSITION_MODE_EXT) |
    (gpio_en & (req_mode_i == TRANSITION_MODE_GPIO));

  // A halted sampler never pulses LOOP_END, so loop modes fire at once.
  always_comb begin
    trig_o = 1'b0;
    unique case (1'b1)
      mode_i == TRANSITION_MODE_SYNC_IDX,
      mode_i == TRANSITION_MODE_EXT:
        trig_o = loop_end_i | halted_i;
      mode_i == TRANSITION_MODE_SYS_TIME:
        trig_o = sys_time_i >= tgt_i;
      mode_i == TRANSITION_MODE_GPIO:
        trig_o = gpio_hit;
      default: trig_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_swap_ctl.sv
// Double-buffer read-segment sequencer with repeat counting.
// AUTD_TRANSITION_GPIO_EN enables GPIO-edge transitions.
module segment_swap_ctl
  import segment_swap_ctl_pkg::*;
#(
  parameter int SysTimeWidth = 56,
  parameter int RepWidth     = 16
) (
  input logic               CLK,
  input logic               RST,
  segment_swap_ctl_if.slave bus
);

  localparam logic [RepWidth-1:0] Inf =
    RepInfinite[RepWidth-1:0];

  swap_state_t state_q, state_d;
  logic seg_q, seg_d;
  logic swap_q, swap_d;
  logic busy_q, busy_d;
  logic stop_q, stop_d;
  logic err_q, err_d;
  logic ext_q, ext_d;
  logic pseg_q, pseg_d;
  logic [7:0] pmode_q, pmode_d;
  logic [1:0] pidx_q, pidx_d;
  logic [SysTimeWidth-1:0] ptgt_q, ptgt_d;
  logic [RepWidth-1:0] cnt_q, cnt_d;

  logic [RepWidth-1:0] limit;
  logic at_lim, trig, mode_ok, req_ok, fire;
  logic unused_val;

  assign unused_val = ^bus.REQ_VALUE[63:SysTimeWidth];

  segment_transition_trigger #(
    .SysTimeWidth(SysTimeWidth)
  ) u_trig (
    .CLK       (CLK),
    .RST       (RST),
    .mode_i    (pmode_q),
    .tgt_i     (ptgt_q),
    .idx_i     (pidx_q),
    .halted_i  (stop_q),
    .loop_end_i(bus.LOOP_END),
    .sys_time_i(bus.SYS_TIME),
    .gpio_i    (bus.GPIO_IN),
    .req_mode_i(bus.REQ_MODE),
    .trig_o    (trig),
    .mode_ok_o (mode_ok)
  );

  assign limit  = seg_q ? bus.REP1 : bus.REP0;
  assign at_lim = (cnt_q == limit) && (limit != Inf);
  assign req_ok = bus.REQ_VALID & mode_ok;
  // A replacing request masks the old request's trigger this cycle.
  assign fire   = (state_q == WAIT) && trig && !req_ok;

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    swap_d  = 1'b0;
    busy_d  = busy_q;
    stop_d  = stop_q;
    err_d   = 1'b0;
    ext_d   = ext_q;
    pseg_d  = pseg_q;
    pmode_d = pmode_q;
    pidx_d  = pidx_q;
    ptgt_d  = ptgt_q;
    cnt_d   = cnt_q;

    if (fire) begin
      seg_d   = pseg_q;
      cnt_d   = '0;
      busy_d  = 1'b0;
      stop_d  = 1'b0;
      swap_d  = 1'b1;
      ext_d   = pmode_q == TRANSITION_MODE_EXT;
      state_d = RUN;
    end else if (bus.LOOP_END && state_q != HALT) begin
      if (at_lim && ext_q) begin
        seg_d  = ~seg_q;
        cnt_d  = '0;
        swap_d = 1'b1;
      end else if (at_lim && state_q == RUN) begin
        stop_d  = 1'b1;
        state_d = HALT;
      end else if (cnt_q != Inf) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (bus.REQ_VALID) begin
      if (mode_ok) begin
        pseg_d  = bus.REQ_SEGMENT;
        pmode_d = bus.REQ_MODE;
        pidx_d  = bus.REQ_VALUE[1:0];
        ptgt_d  = bus.REQ_VALUE[SysTimeWidth-1:0];
        busy_d  = 1'b1;
        state_d = WAIT;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      seg_q   <= 1'b0;
      swap_q  <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
      ext_q   <= 1'b0;
      pseg_q  <= 1'b0;
      pmode_q <= '0;
      pidx_q  <= '0;
      ptgt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      swap_q  <= swap_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
      ext_q   <= ext_d;
      pseg_q  <= pseg_d;
      pmode_q <= pmode_d;
      pidx_q  <= pidx_d;
      ptgt_q  <= ptgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.SEGMENT = seg_q;
  assign bus.SWAP    = swap_q;
  assign bus.BUSY    = busy_q;
  assign bus.STOP    = stop_q;
  assign bus.ERR     = err_q;

endmodule

// File: tb/tb_segment_swap_ctl.sv
// Bench for segment_swap_ctl: cycle model plus directed literal checks.
// Honours AUTD_TRANSITION_GPIO_EN the same way as the design.
module tb_segment_swap_ctl;
  import segment_swap_ctl_pkg::*;

`ifdef AUTD_TRANSITION_GPIO_EN
  localparam bit GpioEn = 1'b1;
`else
  localparam bit GpioEn = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errs = 0;
  int   checks = 0;
  bit   chk_on = 1'b0;

  always #5 CLK = ~CLK;

  segment_swap_ctl_if #(.SysTimeWidth(56), .RepWidth(16)) bus ();

  segment_swap_ctl #(
    .SysTimeWidth(56),
    .RepWidth(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Expected outputs and model state.
  bit e_seg, e_swap, e_busy, e_stop, e_err;
  bit m_pend, m_pseg, m_ext;
  logic [7:0] m_pmode;
  longint unsigned m_ptgt;
  int m_pidx;
  int m_loops;
  logic [3:0] g_last, g_prev;

  function automatic bit known(logic [7:0] m);
    return m == 8'h00 || m == 8'h01 || m == 8'hF0 ||
           (GpioEn && m == 8'h02);
  endfunction

  always @(posedge CLK) begin : model
    bit good, fire, rise, at_lim;
    int limit;
    rise   = g_last[m_pidx] & ~g_prev[m_pidx];
    g_prev = g_last;
    g_last = bus.GPIO_IN;
    if (RST) begin
      {e_seg, e_swap, e_busy, e_stop, e_err} = '0;
      m_pend = 0; m_pseg = 0; m_ext = 0; m_pmode = 0;
      m_ptgt = 0; m_pidx = 0; m_loops = 0;
      g_last = 0; g_prev = 0;
    end else begin
      good   = bus.REQ_VALID && known(bus.REQ_MODE);
      limit  = e_seg ? int'(bus.REP1) : int'(bus.REP0);
      at_lim = (m_loops == limit) && (limit != 65535);
      e_swap = 0;
      e_err  = 0;
      fire   = 0;
      if (m_pend && !good) begin
        if (m_pmode == 8'h00 || m_pmode == 8'hF0)
          fire = bus.LOOP_END || e_stop;
        else if (m_pmode == 8'h01)
          fire = bus.SYS_TIME >= m_ptgt;
        else
          fire = rise;
      end
      if (fire) begin
        e_seg = m_pseg; m_loops = 0; m_pend = 0;
        e_stop = 0; e_swap = 1; m_ext = (m_pmode == 8'hF0);
      end else if (bus.LOOP_END && (m_pend || !e_stop)) begin
        if (at_lim && m_ext) begin
          e_seg = !e_seg; m_loops = 0; e_swap = 1;
        end else if (at_lim && !m_pend) begin
          e_stop = 1;
        end else if (m_loops < 65535) begin
          m_loops++;
        end
      end
      if (bus.REQ_VALID) begin
        if (good) begin
          m_pend = 1; m_pseg = bus.REQ_SEGMENT; m_pmode = bus.REQ_MODE;
          m_ptgt = bus.REQ_VALUE & 64'h00FF_FFFF_FFFF_FFFF;
          m_pidx = int'(bus.REQ_VALUE[1:0]);
        end else begin
          e_err = 1;
        end
      end
      e_busy = m_pend;
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      checks++;
      if ({bus.SEGMENT, bus.SWAP, bus.BUSY, bus.STOP, bus.ERR} !==
          {e_seg, e_swap, e_busy, e_stop, e_err}) begin
        errs++;
        $display("FAIL model t=%0t seg/swap/busy/stop/err got %b want %b",
                 $time, {bus.SEGMENT, bus.SWAP, bus.BUSY, bus.STOP, bus.ERR},
                 {e_seg, e_swap, e_busy, e_stop, e_err});
      end
    end
  end

  task automatic lit(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    bus.LOOP_END  = 1'b0;
  endtask

  task automatic req(bit s, logic [7:0] m, logic [63:0] v);
    bus.REQ_VALID   = 1'b1;
    bus.REQ_SEGMENT = s;
    bus.REQ_MODE    = m;
    bus.REQ_VALUE   = v;
    cyc();
  endtask

  task automatic le();
    bus.LOOP_END = 1'b1;
    cyc();
  endtask

  function automatic logic [4:0] outs();
    return {bus.SEGMENT, bus.SWAP, bus.BUSY, bus.STOP, bus.ERR};
  endfunction

  bit ext_seq [6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    bus.REQ_VALID = 0; bus.REQ_SEGMENT = 0; bus.REQ_MODE = 0;
    bus.REQ_VALUE = 0; bus.REP0 = 16'hFFFF; bus.REP1 = 16'hFFFF;
    bus.LOOP_END = 0; bus.SYS_TIME = 0; bus.GPIO_IN = 0;
    RST = 1;
    cyc();
    chk_on = 1;
    cyc();
    RST = 0;
    lit("reset_outs", 64'(outs()), 64'h0);

    for (int i = 0; i < 5; i++) begin
      le();
      cyc();
    end
    lit("inf_seg", 64'(bus.SEGMENT), 64'd0);
    lit("inf_stop", 64'(bus.STOP), 64'd0);

    req(1, TRANSITION_MODE_SYNC_IDX, 0);
    lit("sync_busy", 64'(bus.BUSY), 64'd1);
    cyc();
    le();
    lit("sync_swap", 64'(outs()), 64'b11000);
    cyc();
    lit("sync_swap_end", 64'(bus.SWAP), 64'd0);

    bus.SYS_TIME = 990;
    req(0, TRANSITION_MODE_SYS_TIME, 64'd1000);
    for (int t = 990; t <= 1010; t++) begin
      bus.SYS_TIME = 56'(t);
      cyc();
      if (t == 999) lit("time_999", 64'(bus.SEGMENT), 64'd1);
      if (t == 1000) lit("time_1000", 64'(outs()), 64'b01000);
    end

    bus.REP1 = 16'd2;
    req(1, TRANSITION_MODE_SYNC_IDX, 0);
    le();
    for (int i = 1; i <= 3; i++) begin
      le();
      cyc();
      lit("rep_stop", 64'(bus.STOP), 64'(i == 3));
    end
    req(0, TRANSITION_MODE_SYNC_IDX, 0);
    lit("halt_req", 64'(outs()), 64'b10110);
    cyc();
    lit("halt_swap", 64'(outs()), 64'b01000);

    bus.REP0 = 16'd1;
    bus.REP1 = 16'd0;
    req(1, TRANSITION_MODE_EXT, 0);
    le();
    lit("ext_first", 64'(bus.SEGMENT), 64'd1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      le();
      lit("ext_seq", 64'(bus.SEGMENT), 64'(ext_seq[i]));
    end
    req(0, 8'h07, 0);
    lit("bad_mode", 64'(outs()), 64'b10001);
    bus.SYS_TIME = 1010;
    req(1, TRANSITION_MODE_SYS_TIME, 64'hFFFF_FFFF_FFFF_FFFF);
    req(0, TRANSITION_MODE_SYNC_IDX, 0);
    cyc();
    le();
    lit("latest_wins", 64'(outs()), 64'b01000);
    bus.REP0 = 16'hFFFF;
    bus.REP1 = 16'hFFFF;
    cyc();

    req(1, TRANSITION_MODE_GPIO, 64'd2);
    if (GpioEn) begin
      lit("gpio_busy", 64'(bus.BUSY), 64'd1);
      bus.GPIO_IN = 4'b0010;
      repeat (3) cyc();
      lit("gpio_wrong_idx", 64'(bus.SEGMENT), 64'd0);
      bus.GPIO_IN = 4'b0110;
      cyc();
      lit("gpio_edge1", 64'(outs()), 64'b00100);
      cyc();
      lit("gpio_edge2", 64'(outs()), 64'b11000);
    end else begin
      lit("gpio_rejected", 64'(outs()), 64'b00001);
    end
    bus.GPIO_IN = 0;
    cyc();

    req(1, TRANSITION_MODE_SYNC_IDX, 0);
    RST = 1;
    cyc();
    lit("mid_reset", 64'(outs()), 64'h0);
    RST = 0;
    le();
    lit("reset_dropped", 64'(outs()), 64'h0);

    req(1, TRANSITION_MODE_SYNC_IDX, 0);
    bus.REQ_VALID   = 1;
    bus.REQ_SEGMENT = 0;
    bus.REQ_MODE    = TRANSITION_MODE_SYNC_IDX;
    bus.LOOP_END    = 1;
    cyc();
    lit("same_cycle", 64'(outs()), 64'b00100);
    le();
    lit("rearm", 64'(outs()), 64'b01000);
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
